// File: rtl/mouse_pkg.sv
// Shared types, byte-0 field positions and small arithmetic helpers for the
// PS/2 mouse cursor tracker.
package mouse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef struct packed {
    logic       yovf;
    logic       xovf;
    logic       ysign;
    logic       xsign;
    logic       rbtn;
    logic       lbtn;
    logic [7:0] dx;
    logic [7:0] dy;
  } ps2_pkt_t;

  localparam int B0_LBTN  = 0;
  localparam int B0_RBTN  = 1;
  localparam int B0_SYNC  = 3;
  localparam int B0_XSIGN = 4;
  localparam int B0_YSIGN = 5;
  localparam int B0_XOVF  = 6;
  localparam int B0_YOVF  = 7;

  function automatic ps2_pkt_t decode_pkt(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2);
    ps2_pkt_t p;
    p.yovf  = b0[B0_YOVF];
    p.xovf  = b0[B0_XOVF];
    p.ysign = b0[B0_YSIGN];
    p.xsign = b0[B0_XSIGN];
    p.rbtn  = b0[B0_RBTN];
    p.lbtn  = b0[B0_LBTN];
    p.dx    = b1;
    p.dy    = b2;
    return p;
  endfunction

  // A saturated (overflowed) axis carries no trustworthy magnitude, so it moves nothing.
  function automatic logic signed [10:0] axis_delta(input logic sign, input logic ovf,
                                                    input logic [7:0] mag);
    if (ovf) return '0;
    return {{3{sign}}, mag};
  endfunction

  function automatic logic [9:0] clamp_axis(input logic signed [10:0] v,
                                            input logic [9:0] vmax);
    if (v < 11'sd0) return '0;
    if (v > $signed({1'b0, vmax})) return vmax;
    return v[9:0];
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: input synchronizers, ps2_clk falling-edge sampling,
// 11-bit frame FSM and the inactivity timeout.
module ps2_rx
  import mouse_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  input  logic       i_pkt_busy,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_byte_err,
  output logic       o_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          r_c_s1, r_c_s2, r_c_prev;
  logic          r_d_s1, r_d_s2;
  logic          r_sample;
  rx_state_t     r_state, w_state_next;
  logic [7:0]    r_shift, w_shift_next;
  logic [2:0]    r_bit, w_bit_next;
  logic          r_par_ok, w_par_next;
  logic [TW-1:0] r_tmo_cnt;
  logic          w_active, w_tmo;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_c_s1   <= 1'b1;
      r_c_s2   <= 1'b1;
      r_c_prev <= 1'b1;
      r_d_s1   <= 1'b1;
      r_d_s2   <= 1'b1;
      r_sample <= 1'b0;
    end else begin
      r_c_s1   <= i_ps2_clk;
      r_c_s2   <= r_c_s1;
      r_c_prev <= r_c_s2;
      r_d_s1   <= i_ps2_data;
      r_d_s2   <= r_d_s1;
      r_sample <= r_c_prev & ~r_c_s2;
    end
  end

  // The timer only runs while something is half-received: a frame or a packet.
  assign w_active = (r_state != IDLE) || i_pkt_busy;
  assign w_tmo    = w_active && !r_sample && (r_tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_sample || !w_active || w_tmo) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bit    <= '0;
      r_par_ok <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_shift  <= w_shift_next;
      r_bit    <= w_bit_next;
      r_par_ok <= w_par_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit;
    w_par_next   = r_par_ok;
    o_byte_valid = 1'b0;
    o_byte_err   = 1'b0;
    if (w_tmo) begin
      w_state_next = IDLE;
      o_byte_err   = (r_state != IDLE);
    end else if (r_sample) begin
      case (r_state)
        IDLE: begin
          if (!r_d_s2) begin
            w_state_next = DATA;
            w_bit_next   = '0;
          end
        end
        DATA: begin
          w_shift_next = {r_d_s2, r_shift[7:1]};
          w_bit_next   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_next = PARITY;
        end
        PARITY: begin
          w_par_next   = ^{r_shift, r_d_s2};
          w_state_next = STOP;
        end
        STOP: begin
          if (r_d_s2 && r_par_ok) o_byte_valid = 1'b1;
          else                    o_byte_err   = 1'b1;
          w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign o_byte    = r_shift;
  assign o_timeout = w_tmo;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker: assembles 3-byte packets, accumulates clamped cursor
// position and publishes it once per video frame.
module ps2_mouse_tracker
  import mouse_pkg::*;
#(
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 240,
  parameter int TIMEOUT = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       frame_clk,
  output logic [9:0] CursorX,
  output logic [9:0] CursorY,
  output logic       left_btn,
  output logic       right_btn,
  output logic       pkt_valid,
  output logic       frame_err
);

  localparam logic [9:0] X_MAX_V  = 10'(X_MAX);
  localparam logic [9:0] Y_MAX_V  = 10'(Y_MAX);
  localparam logic [9:0] X_INIT_V = 10'(X_INIT);
  localparam logic [9:0] Y_INIT_V = 10'(Y_INIT);

  logic [7:0]         w_byte;
  logic               w_byte_valid, w_byte_err, w_timeout, w_pkt_busy;
  logic [1:0]         r_idx;
  logic [7:0]         r_b0, r_b1;
  logic [9:0]         r_pend_x, r_pend_y, r_pub_x, r_pub_y;
  logic               r_pend_l, r_pend_r, r_pub_l, r_pub_r;
  logic               r_pkt_valid, r_frame_err;
  logic               r_f_s1, r_f_s2, r_f_prev;
  logic               w_publish;
  ps2_pkt_t           w_pkt;
  logic signed [10:0] w_dx, w_dy, w_sum_x, w_sum_y;
  logic [9:0]         w_next_x, w_next_y;

  assign w_pkt_busy = (r_idx != 2'd0);

  ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .i_clk        (Clk),
    .i_rst_n      (Reset_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .i_pkt_busy   (w_pkt_busy),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_byte_err   (w_byte_err),
    .o_timeout    (w_timeout)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_f_s1   <= 1'b0;
      r_f_s2   <= 1'b0;
      r_f_prev <= 1'b0;
    end else begin
      r_f_s1   <= frame_clk;
      r_f_s2   <= r_f_s1;
      r_f_prev <= r_f_s2;
    end
  end

  assign w_publish = r_f_s2 & ~r_f_prev;

  // Screen Y grows downward while PS/2 dy is positive for upward motion.
  assign w_pkt    = decode_pkt(r_b0, r_b1, w_byte);
  assign w_dx     = axis_delta(w_pkt.xsign, w_pkt.xovf, w_pkt.dx);
  assign w_dy     = axis_delta(w_pkt.ysign, w_pkt.yovf, w_pkt.dy);
  assign w_sum_x  = $signed({1'b0, r_pend_x}) + w_dx;
  assign w_sum_y  = $signed({1'b0, r_pend_y}) - w_dy;
  assign w_next_x = clamp_axis(w_sum_x, X_MAX_V);
  assign w_next_y = clamp_axis(w_sum_y, Y_MAX_V);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_idx       <= 2'd0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_pend_x    <= X_INIT_V;
      r_pend_y    <= Y_INIT_V;
      r_pend_l    <= 1'b0;
      r_pend_r    <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_pkt_valid <= 1'b0;
      r_frame_err <= w_byte_err;
      if (w_byte_err || w_timeout) begin
        r_idx <= 2'd0;
      end else if (w_byte_valid) begin
        case (r_idx)
          2'd0: begin
            // Only a byte with the always-one bit set can start a packet.
            if (w_byte[B0_SYNC]) begin
              r_b0  <= w_byte;
              r_idx <= 2'd1;
            end
          end
          2'd1: begin
            r_b1  <= w_byte;
            r_idx <= 2'd2;
          end
          2'd2: begin
            r_pend_x    <= w_next_x;
            r_pend_y    <= w_next_y;
            r_pend_l    <= w_pkt.lbtn;
            r_pend_r    <= w_pkt.rbtn;
            r_pkt_valid <= 1'b1;
            r_idx       <= 2'd0;
          end
          default: r_idx <= 2'd0;
        endcase
      end
    end
  end

  // Publishing samples the pending registers before any same-edge packet update.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pub_x <= X_INIT_V;
      r_pub_y <= Y_INIT_V;
      r_pub_l <= 1'b0;
      r_pub_r <= 1'b0;
    end else if (w_publish) begin
      r_pub_x <= r_pend_x;
      r_pub_y <= r_pend_y;
      r_pub_l <= r_pend_l;
      r_pub_r <= r_pend_r;
    end
  end

  assign CursorX   = r_pub_x;
  assign CursorY   = r_pub_y;
  assign left_btn  = r_pub_l;
  assign right_btn = r_pub_r;
  assign pkt_valid = r_pkt_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Self-checking bench for ps2_mouse_tracker: directed scenarios plus a random
// byte stream, checked against a queue-based packet model.
module tb_ps2_mouse_tracker;

  localparam int HALF = 8;
  localparam int GAP  = 20;
  localparam int TMO  = 2000;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       frame_clk = 1'b0;
  logic [9:0] CursorX, CursorY;
  logic       left_btn, right_btn, pkt_valid, frame_err;

  ps2_mouse_tracker #(.TIMEOUT(TMO)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .frame_clk (frame_clk),
    .CursorX   (CursorX),
    .CursorY   (CursorY),
    .left_btn  (left_btn),
    .right_btn (right_btn),
    .pkt_valid (pkt_valid),
    .frame_err (frame_err)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0, n_err = 0;
  int n_pv = 0, n_fe = 0, m_pv = 0, m_fe = 0;
  int m_pend_x, m_pend_y, m_pend_l, m_pend_r;
  int m_pub_x, m_pub_y, m_pub_l, m_pub_r;
  logic [7:0] m_q[$];
  bit chk_en = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  task automatic m_reset();
    m_pend_x = 320; m_pend_y = 240; m_pend_l = 0; m_pend_r = 0;
    m_pub_x  = 320; m_pub_y  = 240; m_pub_l  = 0; m_pub_r  = 0;
    m_q.delete();
  endtask

  // Packet-level model: a queue of accepted bytes, applied when three are held.
  task automatic m_byte(input logic [7:0] b, input bit good);
    logic [7:0] b0;
    int dx, dy;
    if (!good) begin
      m_fe++;
      m_q.delete();
      return;
    end
    if (m_q.size() == 0 && !b[3]) return;
    m_q.push_back(b);
    if (m_q.size() == 3) begin
      b0 = m_q[0];
      dx = b0[6] ? 0 : (b0[4] ? int'(m_q[1]) - 256 : int'(m_q[1]));
      dy = b0[7] ? 0 : (b0[5] ? int'(m_q[2]) - 256 : int'(m_q[2]));
      m_pend_x = clampi(m_pend_x + dx, 639);
      m_pend_y = clampi(m_pend_y - dy, 479);
      m_pend_l = int'(b0[0]);
      m_pend_r = int'(b0[1]);
      m_pv++;
      $display("pkt %02h %02h %02h dx=%0d dy=%0d -> pending (%0d,%0d) L=%0d R=%0d",
               m_q[0], m_q[1], m_q[2], dx, dy, m_pend_x, m_pend_y, m_pend_l, m_pend_r);
      m_q.delete();
    end
  endtask

  // Published outputs are compared on every cycle.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("CursorX", CursorX, m_pub_x);
      check("CursorY", CursorY, m_pub_y);
      check("left_btn", left_btn, m_pub_l);
      check("right_btn", right_btn, m_pub_r);
    end
  end

  always @(negedge Clk) begin
    if (pkt_valid === 1'b1) n_pv++;
    if (frame_err === 1'b1) n_fe++;
  end

  task automatic check_counts(input string tag);
    check({tag, " pkt_valid pulses"}, n_pv, m_pv);
    check({tag, " frame_err pulses"}, n_fe, m_fe);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input bit collide);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = fr[i];
      repeat (HALF) @(posedge Clk);
      #1 ps2_clk = 1'b0;
      if (collide && i == 10) begin
        @(posedge Clk);
        #1 frame_clk = 1'b1;
        repeat (3) begin
          @(posedge Clk);
          #1;
        end
        check("pkt_valid on collision edge", pkt_valid, 1);
        m_pub_x = m_pend_x; m_pub_y = m_pend_y; m_pub_l = m_pend_l; m_pub_r = m_pend_r;
        frame_clk = 1'b0;
        repeat (HALF - 4) @(posedge Clk);
      end else begin
        repeat (HALF) @(posedge Clk);
      end
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (GAP) @(posedge Clk);
    #1;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_byte(b, 1'b0, 1'b0, 1'b0);
    m_byte(b, 1'b1);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_good(b0);
    send_good(b1);
    send_good(b2);
  endtask

  task automatic send_partial(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = (i == 0) ? 1'b0 : 1'($urandom_range(1));
      repeat (HALF) @(posedge Clk);
      #1 ps2_clk = 1'b0;
      repeat (HALF) @(posedge Clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic frame_pulse();
    @(posedge Clk);
    #1 frame_clk = 1'b1;
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    m_pub_x = m_pend_x; m_pub_y = m_pend_y; m_pub_l = m_pend_l; m_pub_r = m_pend_r;
    repeat (2) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    m_reset();
    #2;
    check("async reset CursorX", CursorX, 320);
    check("async reset CursorY", CursorY, 240);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    bit bad;
    m_reset();
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    chk_en = 1'b1;
    check("reset pkt_valid", pkt_valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset left_btn", left_btn, 0);

    // Basic packet
    send_pkt(8'h08, 8'd10, 8'd5);
    frame_pulse();
    check("basic CursorX", CursorX, 330);
    check("basic CursorY", CursorY, 235);
    check_counts("basic");

    // Clamp at both X edges
    do_reset();
    send_pkt(8'h18, 8'h00, 8'h00);
    send_pkt(8'h18, 8'h00, 8'h00);
    frame_pulse();
    check("clamp low CursorX", CursorX, 0);
    for (int i = 0; i < 5; i++) send_pkt(8'h08, 8'h7F, 8'h00);
    frame_pulse();
    check("5x127 CursorX", CursorX, 635);
    send_pkt(8'h08, 8'h7F, 8'h00);
    frame_pulse();
    check("clamp high CursorX", CursorX, 639);
    check_counts("clamp");

    // Bad parity on byte 1, then a clean packet
    send_good(8'h08);
    send_byte(8'h05, 1'b1, 1'b0, 1'b0);
    m_byte(8'h05, 1'b0);
    frame_pulse();
    check("bad parity CursorX", CursorX, 639);
    check_counts("parity");
    send_pkt(8'h18, 8'hF6, 8'h00);
    frame_pulse();
    check("after parity CursorX", CursorX, 629);

    // Unsynchronised first byte is dropped
    send_good(8'h00);
    send_pkt(8'h08, 8'h05, 8'h0A);
    frame_pulse();
    check("resync CursorX", CursorX, 634);
    check("resync CursorY", CursorY, 230);
    check_counts("resync");

    // Idle timeout between bytes (silent) and inside a frame (reported)
    send_good(8'h08);
    send_good(8'h01);
    repeat (TMO + 1000) @(posedge Clk);
    m_q.delete();
    send_pkt(8'h08, 8'h02, 8'h00);
    frame_pulse();
    check("packet timeout CursorX", CursorX, 636);
    check_counts("pkt timeout");
    send_partial(4);
    repeat (TMO + 1000) @(posedge Clk);
    m_q.delete();
    m_fe++;
    send_pkt(8'h08, 8'h01, 8'h00);
    frame_pulse();
    check("frame timeout CursorX", CursorX, 637);
    check_counts("frame timeout");

    // Overflow, buttons, and publish colliding with packet acceptance
    send_pkt(8'h49, 8'h7F, 8'h00);
    frame_pulse();
    check("ovf left_btn", left_btn, 1);
    check("ovf CursorX", CursorX, 637);
    send_pkt(8'h1A, 8'hFD, 8'h00);
    send_good(8'h18);
    send_good(8'hFC);
    send_byte(8'h00, 1'b0, 1'b0, 1'b1);
    m_byte(8'h00, 1'b1);
    check("collision CursorX", CursorX, 634);
    check("collision right_btn", right_btn, 1);
    frame_pulse();
    check("post collision CursorX", CursorX, 630);
    check("post collision right_btn", right_btn, 0);
    check_counts("collision");

    // Reset in the middle of a packet
    send_good(8'h08);
    send_good(8'h05);
    do_reset();
    send_pkt(8'h08, 8'h01, 8'h00);
    frame_pulse();
    check("mid-packet reset CursorX", CursorX, 321);
    check_counts("reset");

    // Random byte stream with occasional framing errors
    for (int i = 0; i < 60; i++) begin
      b = 8'($urandom);
      if (m_q.size() == 0 && $urandom_range(3) != 0) b[3] = 1'b1;
      bad = ($urandom_range(9) == 0);
      if (bad) begin
        if ($urandom_range(1) == 0) send_byte(b, 1'b1, 1'b0, 1'b0);
        else                        send_byte(b, 1'b0, 1'b1, 1'b0);
      end else begin
        send_byte(b, 1'b0, 1'b0, 1'b0);
      end
      m_byte(b, !bad);
      if ($urandom_range(4) == 0) frame_pulse();
    end
    frame_pulse();
    check_counts("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
